// File: rtl/btb_arbiter.sv
// Arbitrates a single-ported BTB between fetch lookups and buffered execute-stage updates.
// Lookups win, but a starvation counter forces a queued update through after STARVE_LIMIT grants.
module btb_arbiter #(
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_read,
    input  logic [31:0] if_pc,
    output logic        if_resp,
    output logic [31:0] if_target,
    output logic        if_hit,
    input  logic        ex_update,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    output logic        ex_stall,
    output logic        btb_read,
    output logic        btb_write,
    output logic [31:0] btb_address,
    output logic [31:0] btb_wdata,
    input  logic [31:0] btb_rdata,
    input  logic        btb_hit,
    input  logic        btb_resp
);

    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FULL_COUNT = QDEPTH[PW:0];
    localparam logic [PW:0]   ZERO_COUNT = {(PW + 1){1'b0}};
    localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT[SW-1:0];

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    next_state_s;
    logic [31:0]   addr_r;
    logic [31:0]   q_pc_r     [QDEPTH];
    logic [31:0]   q_target_r [QDEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count_r;
    logic [SW-1:0] starve_r;
    logic          push_s;
    logic          pop_s;
    logic          grant_lookup_s;
    logic          grant_update_s;
    logic          queued_s;

    assign queued_s = (count_r != ZERO_COUNT);

    // Next-state decode and grant selection; a starved queue outranks a pending lookup.
    always_comb begin
        next_state_s   = state_r;
        grant_lookup_s = 1'b0;
        grant_update_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (queued_s && (starve_r == STARVE_MAX)) begin
                    next_state_s   = UPDATE;
                    grant_update_s = 1'b1;
                end else if (if_read) begin
                    next_state_s   = LOOKUP;
                    grant_lookup_s = 1'b1;
                end else if (queued_s) begin
                    next_state_s   = UPDATE;
                    grant_update_s = 1'b1;
                end else begin
                    next_state_s   = IDLE;
                end
            end
            LOOKUP: begin
                if (btb_resp) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOOKUP;
                end
            end
            UPDATE: begin
                if (btb_resp) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = UPDATE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // A full queue refuses the push even when the head retires in the same cycle.
    assign ex_stall = (count_r == FULL_COUNT);
    assign push_s   = ex_update & ex_taken & ~ex_stall;
    assign pop_s    = (state_r == UPDATE) & btb_resp;

    // Control state: FSM, latched BTB address, FIFO pointers and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            addr_r   <= 32'd0;
            head_r   <= {PW{1'b0}};
            tail_r   <= {PW{1'b0}};
            count_r  <= ZERO_COUNT;
            starve_r <= {SW{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (grant_lookup_s) begin
                addr_r <= if_pc;
            end else if (grant_update_s) begin
                addr_r <= q_pc_r[head_r];
            end
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s) begin
                starve_r <= {SW{1'b0}};
            end else if (grant_lookup_s && queued_s && (starve_r != STARVE_MAX)) begin
                starve_r <= starve_r + SW'(1);
            end
        end
    end

    // Queue payload storage; occupancy is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_pc_r[tail_r]     <= ex_pc;
            q_target_r[tail_r] <= ex_target;
        end
    end

    assign btb_read    = (state_r == LOOKUP);
    assign btb_write   = (state_r == UPDATE);
    assign btb_address = (btb_read | btb_write) ? addr_r : 32'd0;
    assign btb_wdata   = btb_write ? q_target_r[head_r] : 32'd0;
    assign if_resp     = btb_read & btb_resp;
    assign if_target   = if_resp ? btb_rdata : 32'd0;
    assign if_hit      = if_resp & btb_hit;

endmodule
